pipe_rca: RTL and testbench
===========================

// Module: pipe_rca
//
// PURPOSE
// - Parametrised, pipelined ripple-carry adder: successor to the fixed 8-bit combinational RCA.
// - Splits a WIDTH-bit add into STAGES equal chunks. One chunk is resolved per clock, and the carry is registered between chunks.
// - Valid/ready streaming interface on both sides. Sits between operand producers and the datapath accumulator.
// - Sustains one add per cycle, with latency STAGES.
//
// PARAMETERS
// - WIDTH   32  operand/sum width in bits; must be a multiple of STAGES
// - STAGES  4   pipeline depth = number of chunks; 1 <= STAGES <= WIDTH
// - CW      WIDTH/STAGES (localparam) chunk width
//
// PORTS
// - clk        in   1      rising-edge clock
// - rstn       in   1      asynchronous, active-low reset
// - in_valid   in   1      a/b/ci hold a valid operation
// - in_ready   out  1      block can accept an operation this cycle
// - a          in   WIDTH  operand A (unsigned)
// - b          in   WIDTH  operand B (unsigned)
// - ci         in   1      carry in
// - out_valid  out  1      s/co hold a finished result
// - out_ready  in   1      consumer accepts the result this cycle
// - s          out  WIDTH  sum
// - co         out  1      carry out of bit WIDTH-1
// - ovf        out  1      signed overflow (present only with PRCA_OVF_EN)
//
// BEHAVIOUR
// - Reset (rstn=0, async): all valid bits cleared; s=0, co=0, ovf=0; in_ready=1 once rstn=1.
//   - Any in-flight operation is discarded and no partial result appears after release.
// - Stage k (0..STAGES-1):
//   - adds chunk k of a/b plus the carry registered from stage k-1 (stage 0 uses ci).
//   - registers the CW-bit partial sum and the carry.
//   - stage k carries the untouched upper chunks k+1..STAGES-1 of a/b forward.
//   - stage k carries the already-resolved lower chunks forward.
// - Each stage has a valid bit. The output register is the last stage.
// - Latency: an op accepted at edge N appears on s/co with out_valid=1 after edge N+STAGES, assuming no stall.
// - Throughput: 1 op/cycle. Back-to-back ops never interfere.
// - Handshake:
//   - Accept when in_valid & in_ready. Deliver when out_valid & out_ready.
//   - stall = out_valid & ~out_ready. When stall=1, every pipeline register holds, and in_ready=0 (combinational).
//   - Bubbles (invalid stages) advance normally; the block does not compress bubbles.
//   - s/co hold stable while out_valid=1 and out_ready=0.
//   - s/co are don't-care when out_valid=0, but must not toggle X.
// - Arithmetic: {co,s} = a + b + ci, modulo 2^(WIDTH+1).
//   - Wrap: a=all-ones, b=0, ci=1 -> s=0, co=1.
// - Simultaneous out_ready and in_valid while the output is full: the result drains and the new op enters on the same edge.
// - STAGES=1: behaves as a registered adder with latency 1.
// - Inputs are sampled only on acceptance. a/b/ci may change freely otherwise.
//
// CONFIGURATION
// - Macro PRCA_OVF_EN:
//   - Defined: port ovf exists. The final stage also registers the carry into the MSB.
//     ovf = carry_into_msb ^ co, aligned with s/co, reset 0, held under stall.
//   - Undefined: port ovf and its logic are absent. All other behaviour is identical.
//
// TESTING (bench: WIDTH=8, STAGES=2 unless noted; out_ready=1 unless noted)
// - Reset release, no input -> out_valid=0, s=0, co=0 for 10 cycles; in_ready=1.
// - a=255, b=1, ci=0 accepted at edge N -> at edge N+2, out_valid=1, s=0, co=1.
//   - With PRCA_OVF_EN: a=127, b=1 -> s=128, ovf=1.
// - Stream 100 random a/b/ci, one per cycle -> 100 results in order, each {co,s}==a+b+ci; out_valid high for 100 consecutive cycles.
// - Hold out_ready=0 for 5 cycles with a full pipe -> s/co frozen, in_ready=0, no op lost or duplicated after release.
// - Pull rstn low while 2 ops are in flight, then release -> out_valid=0 and no stale result emerges within 4 cycles.
// - WIDTH=32, STAGES=4: a=32'hFFFF_FFFF, b=0, ci=1 -> after 4 cycles s=0, co=1 (carry crosses all stages).

Source files
------------

// File: rtl/pipe_rca_if.sv
// Streaming bundle for the pipelined ripple-carry adder: operand side
// (in_valid/in_ready/a/b/ci) and result side (out_valid/out_ready/s/co).
// Optional macro PRCA_OVF_EN adds the signed-overflow flag ovf.
interface pipe_rca_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef PRCA_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
`else
  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co
  );
`endif
endinterface

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder. A WIDTH-bit add is split into STAGES chunks
// of CW bits; one chunk is resolved per clock with the carry registered
// between chunks. Operands are captured on acceptance, then pass through
// STAGES chunk stages, the last of which is the output register, so a
// result appears STAGES edges after the edge that accepted it.
// Optional macro PRCA_OVF_EN adds a registered signed-overflow flag.
module pipe_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic      clk,
  input logic      rstn,
  pipe_rca_if.slave bus
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Operand capture register feeding chunk stage 0
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;
  logic             in_c_q;
  logic             in_v_q;

  // Chunk stage registers: upper operand chunks travel forward unchanged,
  // lower sum chunks accumulate as they are resolved
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  // Values each stage sees from its predecessor, and what it will register
  logic [WIDTH-1:0] pa [STAGES];
  logic [WIDTH-1:0] pb [STAGES];
  logic [WIDTH-1:0] ps [STAGES];
  logic             pc [STAGES];
  logic             pv [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic             nc [STAGES];
  logic [CW:0]      chunk;

  logic stall;

`ifdef PRCA_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif

  assign stall         = v_q[LAST] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v_q[LAST];
  assign bus.s         = s_q[LAST];
  assign bus.co        = c_q[LAST];

  // Resolve chunk k of each stage from the previous stage's registers
  always_comb begin
    chunk = '0;
    pa[0] = in_a_q;
    pb[0] = in_b_q;
    ps[0] = '0;
    pc[0] = in_c_q;
    pv[0] = in_v_q;
    for (int k = 1; k < STAGES; k++) begin
      pa[k] = a_q[k-1];
      pb[k] = b_q[k-1];
      ps[k] = s_q[k-1];
      pc[k] = c_q[k-1];
      pv[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, pa[k][k*CW +: CW]} + {1'b0, pb[k][k*CW +: CW]}
            + {{CW{1'b0}}, pc[k]};
      ns[k] = ps[k];
      ns[k][k*CW +: CW] = chunk[CW-1:0];
      nc[k] = chunk[CW];
    end
  end

  // Advance the whole pipe (bubbles included) unless the output is stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_a_q <= '0;
      in_b_q <= '0;
      in_c_q <= 1'b0;
      in_v_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
`ifdef PRCA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (!stall) begin
      in_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        in_a_q <= bus.a;
        in_b_q <= bus.b;
        in_c_q <= bus.ci;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= pa[k];
        b_q[k] <= pb[k];
        s_q[k] <= ns[k];
        c_q[k] <= nc[k];
        v_q[k] <= pv[k];
      end
`ifdef PRCA_OVF_EN
      // carry into the MSB is a^b^sum at that bit; overflow is it xor co
      ovf_q <= pa[LAST][WIDTH-1] ^ pb[LAST][WIDTH-1] ^ ns[LAST][WIDTH-1] ^ nc[LAST];
`endif
    end
  end

endmodule

// File: tb/tb_pipe_rca.sv
// Self-checking bench for pipe_rca: narrow instance (WIDTH=8, STAGES=2)
// and wide instance (WIDTH=32, STAGES=4). Honours PRCA_OVF_EN when defined.
module tb_pipe_rca;

  logic clk;
  logic rstn;

  int checks;
  int errors;

  pipe_rca_if #(.WIDTH(8))  nb ();
  pipe_rca_if #(.WIDTH(32)) wb ();

  pipe_rca #(.WIDTH(8), .STAGES(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (nb)
  );

  pipe_rca #(.WIDTH(32), .STAGES(4)) dut_wide (
    .clk  (clk),
    .rstn (rstn),
    .bus  (wb)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] exp_s;
    logic       exp_co;
  } vec_t;

  vec_t       vecs [10];
  logic [8:0] exp_q [$];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic ci);
    nb.in_valid = 1'b1;
    nb.a        = a;
    nb.b        = b;
    nb.ci       = ci;
  endtask

  task automatic apply_idle();
    nb.in_valid = 1'b0;
  endtask

  // Single op through the narrow pipe; waits (bounded) for its result
  task automatic run_vector(input string name, input vec_t v);
    bit seen;
    seen = 1'b0;
    apply_stimulus(v.a, v.b, v.ci);
    @(negedge clk);
    apply_idle();
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (nb.out_valid) begin
        seen = 1'b1;
        check_output({name, "_s"}, 64'(nb.s), 64'(v.exp_s));
        check_output({name, "_co"}, 64'(nb.co), 64'(v.exp_co));
      end
    end
    if (!seen) check_output({name, "_timeout"}, 64'(0), 64'(1));
    @(negedge clk);
  endtask

  // Compare a delivered narrow result against the head of the model queue
  task automatic pop_and_compare(input string name);
    if (exp_q.size() == 0) begin
      check_output({name, "_unexpected"}, 64'({nb.co, nb.s}), 64'h1FF_DEAD);
    end else begin
      check_output(name, 64'({nb.co, nb.s}), 64'(exp_q.pop_front()));
    end
  endtask

  function automatic logic [8:0] model_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic ci);
    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
  endfunction

  initial begin
    int received;
    int run;
    int max_run;
    int sent;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    checks = 0;
    errors = 0;

    vecs[0] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    vecs[1] = '{8'd1,   8'd1,   1'b0, 8'd2,   1'b0};
    vecs[2] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
    vecs[3] = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1};
    vecs[4] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
    vecs[5] = '{8'd15,  8'd1,   1'b0, 8'd16,  1'b0};
    vecs[6] = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1};
    vecs[7] = '{8'h5A,  8'hA5,  1'b0, 8'hFF,  1'b0};
    vecs[8] = '{8'h5A,  8'hA5,  1'b1, 8'h00,  1'b1};
    vecs[9] = '{8'd100, 8'd27,  1'b1, 8'd128, 1'b0};

    rstn         = 1'b0;
    nb.in_valid  = 1'b0;
    nb.a         = '0;
    nb.b         = '0;
    nb.ci        = 1'b0;
    nb.out_ready = 1'b1;
    wb.in_valid  = 1'b0;
    wb.a         = '0;
    wb.b         = '0;
    wb.ci        = 1'b0;
    wb.out_ready = 1'b1;

    // Reset release with no input
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("rst_out_valid", 64'(nb.out_valid), 64'(0));
      check_output("rst_s", 64'(nb.s), 64'(0));
      check_output("rst_co", 64'(nb.co), 64'(0));
      check_output("rst_in_ready", 64'(nb.in_ready), 64'(1));
`ifdef PRCA_OVF_EN
      check_output("rst_ovf", 64'(nb.ovf), 64'(0));
`endif
    end
    check_output("rst_wide_out_valid", 64'(wb.out_valid), 64'(0));

    // Latency: accepted at edge N, visible after edge N+2
    apply_stimulus(8'd255, 8'd1, 1'b0);
    @(negedge clk);
    apply_idle();
    check_output("lat_after_n", 64'(nb.out_valid), 64'(0));
    @(negedge clk);
    check_output("lat_after_n1", 64'(nb.out_valid), 64'(0));
    @(negedge clk);
    check_output("lat_after_n2_valid", 64'(nb.out_valid), 64'(1));
    check_output("lat_s", 64'(nb.s), 64'(0));
    check_output("lat_co", 64'(nb.co), 64'(1));
    @(negedge clk);
    check_output("lat_drained", 64'(nb.out_valid), 64'(0));

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_vector($sformatf("vec%0d", i), vecs[i]);
    end

`ifdef PRCA_OVF_EN
    // Signed overflow: 127 + 1
    apply_stimulus(8'd127, 8'd1, 1'b0);
    @(negedge clk);
    apply_idle();
    @(negedge clk);
    @(negedge clk);
    check_output("ovf_valid", 64'(nb.out_valid), 64'(1));
    check_output("ovf_s", 64'(nb.s), 64'(128));
    check_output("ovf_flag", 64'(nb.ovf), 64'(1));
    @(negedge clk);
`endif

    // Back-to-back stream of 100 random ops
    exp_q.delete();
    received = 0;
    run      = 0;
    max_run  = 0;
    sent     = 0;
    for (int cyc = 0; cyc < 112; cyc++) begin
      if (nb.out_valid) begin
        pop_and_compare($sformatf("stream%0d", received));
        received++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (sent < 100) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 1'($urandom_range(0, 1));
        apply_stimulus(ra, rb, rc);
        exp_q.push_back(model_add(ra, rb, rc));
        sent++;
      end else begin
        apply_idle();
      end
      @(negedge clk);
    end
    check_output("stream_count", 64'(received), 64'(100));
    check_output("stream_consecutive", 64'(max_run), 64'(100));
    check_output("stream_leftover", 64'(exp_q.size()), 64'(0));

    // Stall with a full pipe for 5 cycles, then drain
    exp_q.delete();
    nb.out_ready = 1'b0;
    apply_stimulus(8'd10, 8'd20, 1'b0);
    exp_q.push_back(model_add(8'd10, 8'd20, 1'b0));
    @(negedge clk);
    apply_stimulus(8'd200, 8'd100, 1'b1);
    exp_q.push_back(model_add(8'd200, 8'd100, 1'b1));
    @(negedge clk);
    apply_stimulus(8'd15, 8'd15, 1'b1);
    exp_q.push_back(model_add(8'd15, 8'd15, 1'b1));
    @(negedge clk);
    apply_stimulus(8'd255, 8'd255, 1'b0);
    exp_q.push_back(model_add(8'd255, 8'd255, 1'b0));
    for (int i = 0; i < 5; i++) begin
      check_output("stall_valid", 64'(nb.out_valid), 64'(1));
      check_output("stall_in_ready", 64'(nb.in_ready), 64'(0));
      check_output("stall_result", 64'({nb.co, nb.s}), 64'(9'd30));
      @(negedge clk);
    end
    nb.out_ready = 1'b1;
    received = 0;
    for (int i = 0; i < 10; i++) begin
      if (nb.out_valid) begin
        pop_and_compare($sformatf("stall_drain%0d", received));
        received++;
      end
      if (i > 0) apply_idle();
      @(negedge clk);
    end
    check_output("stall_drain_count", 64'(received), 64'(4));
    check_output("stall_leftover", 64'(exp_q.size()), 64'(0));

    // Reset with two ops in flight
    apply_stimulus(8'd1, 8'd2, 1'b0);
    @(negedge clk);
    apply_stimulus(8'd3, 8'd4, 1'b1);
    @(negedge clk);
    apply_idle();
    rstn = 1'b0;
    #1;
    check_output("inflight_rst_valid", 64'(nb.out_valid), 64'(0));
    check_output("inflight_rst_s", 64'(nb.s), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("inflight_no_stale", 64'(nb.out_valid), 64'(0));
    end

    // Wide pipe: carry crosses all four stages
    wb.in_valid = 1'b1;
    wb.a        = 32'hFFFF_FFFF;
    wb.b        = 32'h0;
    wb.ci       = 1'b1;
    @(negedge clk);
    wb.in_valid = 1'b0;
    check_output("wide_after_n", 64'(wb.out_valid), 64'(0));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_output($sformatf("wide_after_n%0d", i), 64'(wb.out_valid), 64'(0));
    end
    @(negedge clk);
    check_output("wide_valid", 64'(wb.out_valid), 64'(1));
    check_output("wide_s", 64'(wb.s), 64'(0));
    check_output("wide_co", 64'(wb.co), 64'(1));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
